// File: rtl/csr_acu_pkg.sv
// rtl/csr_acu_pkg.sv - shared op encodings, FSM state type and address constants for csr_access_unit
package csr_acu_pkg;

  typedef enum logic [1:0] {
    OP_RSV = 2'b00,
    OP_RW  = 2'b01,
    OP_RS  = 2'b10,
    OP_RC  = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } acu_state_e;

  // addr[11:10] value marking the read-only CSR space
  localparam logic [1:0] RO_ADDR_FIELD = 2'b11;

endpackage

// File: rtl/csr_acu_alu.sv
// rtl/csr_acu_alu.sv - combinational new-value computation for CSR read-write, read-set and read-clear
module csr_acu_alu
  import csr_acu_pkg::*;
#(
  parameter int C_XLEN = 32
) (
  input  csr_op_e           op_i,
  input  logic [C_XLEN-1:0] old_i,
  input  logic [C_XLEN-1:0] operand_i,
  output logic [C_XLEN-1:0] new_o
);

  always_comb begin
    new_o = operand_i;
    case (op_i)
      OP_RS:   new_o = old_i | operand_i;
      OP_RC:   new_o = old_i & ~operand_i;
      default: new_o = operand_i;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - CSR read-modify-write sequencer (IDLE/READ/WRITE/RESP)
// Optional CSR_ACU_RO_TRAP_EN: trap writes to the read-only address space locally.
module csr_access_unit
  import csr_acu_pkg::*;
#(
  parameter int C_XLEN = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clk_en_i,
  input  logic              req_i,
  output logic              req_ready_o,
  input  logic [1:0]        op_i,
  input  logic              imm_i,
  input  logic [11:0]       addr_i,
  input  logic [C_XLEN-1:0] rs1_data_i,
  input  logic [4:0]        zimm_i,
  input  logic              rs1_zero_i,
  input  logic              rd_zero_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [C_XLEN-1:0] rsp_data_o,
  output logic              rsp_exc_o,
  output logic              csr_rd_o,
  output logic [11:0]       csr_rd_addr_o,
  input  logic [C_XLEN-1:0] csr_rd_data_i,
  output logic              csr_wr_o,
  output logic [11:0]       csr_wr_addr_o,
  output logic [C_XLEN-1:0] csr_wr_data_o,
  input  logic              csr_illegal_rd_i,
  input  logic              csr_illegal_wr_i
);

  acu_state_e        state_q;
  csr_op_e           op_q;
  logic [11:0]       addr_q;
  logic [C_XLEN-1:0] operand_q;
  logic [C_XLEN-1:0] wdata_q;
  logic [C_XLEN-1:0] rdata_q;
  logic              operand_nz_q;
  logic              rd_zero_q;
  logic              exc_q;

  logic              rd_en;
  logic              wr_en;
  logic              ro_hit;
  logic              exc_now;
  logic [C_XLEN-1:0] new_val;

  // RW into x0 has no architectural read; RS/RC with a zero operand must not write
  assign rd_en = !(op_q == OP_RW && rd_zero_q);
  assign wr_en = (op_q == OP_RW) || operand_nz_q;

`ifdef CSR_ACU_RO_TRAP_EN
  assign ro_hit = wr_en && (addr_q[11:10] == RO_ADDR_FIELD);
`else
  assign ro_hit = 1'b0;
`endif

  assign exc_now = (rd_en && csr_illegal_rd_i) || (wr_en && csr_illegal_wr_i) || ro_hit;

  csr_acu_alu #(.C_XLEN(C_XLEN)) u_alu (
    .op_i      (op_q),
    .old_i     (csr_rd_data_i),
    .operand_i (operand_q),
    .new_o     (new_val)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_RSV;
      addr_q       <= '0;
      operand_q    <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      operand_nz_q <= 1'b0;
      rd_zero_q    <= 1'b0;
      exc_q        <= 1'b0;
    end else if (clk_en_i) begin
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            op_q         <= csr_op_e'(op_i);
            addr_q       <= addr_i;
            operand_q    <= imm_i ? {{(C_XLEN-5){1'b0}}, zimm_i} : rs1_data_i;
            operand_nz_q <= imm_i ? (zimm_i != 5'd0) : !rs1_zero_i;
            rd_zero_q    <= rd_zero_i;
            rdata_q      <= '0;
            exc_q        <= (csr_op_e'(op_i) == OP_RSV);
            state_q      <= (csr_op_e'(op_i) == OP_RSV) ? ST_RESP : ST_READ;
          end
        end
        ST_READ: begin
          exc_q   <= exc_now;
          rdata_q <= (rd_en && !exc_now) ? csr_rd_data_i : '0;
          wdata_q <= new_val;
          state_q <= (exc_now || !wr_en) ? ST_RESP : ST_WRITE;
        end
        ST_WRITE: state_q <= ST_RESP;
        ST_RESP: begin
          if (rsp_ready_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o   = (state_q == ST_IDLE);
  assign rsp_valid_o   = (state_q == ST_RESP);
  assign rsp_data_o    = rdata_q;
  assign rsp_exc_o     = exc_q;
  assign csr_rd_o      = (state_q == ST_READ) && clk_en_i && rd_en;
  assign csr_rd_addr_o = addr_q;
  assign csr_wr_o      = (state_q == ST_WRITE) && clk_en_i;
  assign csr_wr_addr_o = addr_q;
  assign csr_wr_data_o = wdata_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// tb/tb_csr_access_unit.sv - randomized and directed self-checking bench for csr_access_unit
module tb_csr_access_unit;

  logic        clk_i = 1'b0;
  logic        reset_i, clk_en_i, req_i, req_ready_o;
  logic [1:0]  op_i;
  logic        imm_i;
  logic [11:0] addr_i;
  logic [31:0] rs1_data_i;
  logic [4:0]  zimm_i;
  logic        rs1_zero_i, rd_zero_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_exc_o;
  logic [31:0] rsp_data_o;
  logic        csr_rd_o, csr_wr_o, csr_illegal_rd_i, csr_illegal_wr_i;
  logic [11:0] csr_rd_addr_o, csr_wr_addr_o;
  logic [31:0] csr_rd_data_i, csr_wr_data_o;

  always #5 clk_i = ~clk_i;

  csr_access_unit #(.C_XLEN(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i),
    .req_i(req_i), .req_ready_o(req_ready_o), .op_i(op_i), .imm_i(imm_i),
    .addr_i(addr_i), .rs1_data_i(rs1_data_i), .zimm_i(zimm_i),
    .rs1_zero_i(rs1_zero_i), .rd_zero_i(rd_zero_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_exc_o(rsp_exc_o),
    .csr_rd_o(csr_rd_o), .csr_rd_addr_o(csr_rd_addr_o), .csr_rd_data_i(csr_rd_data_i),
    .csr_wr_o(csr_wr_o), .csr_wr_addr_o(csr_wr_addr_o), .csr_wr_data_o(csr_wr_data_o),
    .csr_illegal_rd_i(csr_illegal_rd_i), .csr_illegal_wr_i(csr_illegal_wr_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // transaction-level model: what the current access must do, and how far it has progressed
  bit          chk_en = 0;
  bit          m_busy = 0;
  int          m_age, m_rsp_at, txn_id = 0;
  bit          m_rd, m_wr, m_exc;
  logic [11:0] m_addr = '0;
  logic [31:0] m_new, m_old, csr_val = '0;

  // CSR file: returns the stored value only for the address under access
  assign csr_rd_data_i = (csr_rd_addr_o == m_addr) ? csr_val : ~csr_val;

  int          obs_rd_cnt = 0, obs_wr_cnt = 0, obs_val_cnt = 0;
  int          obs_rd_age, obs_wr_age, obs_rsp_age, obs_tid_rd = -1, obs_tid_rsp = -1;
  logic [31:0] obs_wr_data, obs_rsp_data;
  bit          obs_rsp_exc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (txn %0d, t=%0t)", name, act, exp, txn_id, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      bit e_rd, e_wr, e_val;
      e_rd  = m_busy && m_age == 1 && m_rsp_at > 1 && m_rd && clk_en_i;
      e_wr  = m_busy && m_age == 2 && m_wr && clk_en_i;
      e_val = m_busy && m_age >= m_rsp_at;
      check("req_ready", req_ready_o, !m_busy);
      check("csr_rd", csr_rd_o, e_rd);
      check("csr_wr", csr_wr_o, e_wr);
      check("rsp_valid", rsp_valid_o, e_val);
      if (e_rd) check("csr_rd_addr", csr_rd_addr_o, m_addr);
      if (e_wr) begin
        check("csr_wr_addr", csr_wr_addr_o, m_addr);
        check("csr_wr_data", csr_wr_data_o, m_new);
      end
      if (e_val) begin
        check("rsp_data", rsp_data_o, m_old);
        check("rsp_exc", rsp_exc_o, m_exc);
      end
      if (csr_rd_o) begin
        obs_rd_cnt++;
        if (obs_tid_rd != txn_id) begin obs_tid_rd = txn_id; obs_rd_age = m_age; end
      end
      if (csr_wr_o) begin
        obs_wr_cnt++;
        obs_wr_data = csr_wr_data_o;
        obs_wr_age  = m_age;
      end
      if (rsp_valid_o) begin
        obs_val_cnt++;
        if (obs_tid_rsp != txn_id) begin
          obs_tid_rsp  = txn_id;
          obs_rsp_age  = m_age;
          obs_rsp_data = rsp_data_o;
          obs_rsp_exc  = rsp_exc_o;
        end
      end
    end
  end

  // Caller is at posedge+1. rnd randomizes clk_en/rsp_ready; hold delays rsp_ready in directed mode;
  // abort_at pulses reset once the access has seen that many enabled edges.
  task automatic run_txn(input logic [1:0] op, input bit imm, input logic [11:0] addr,
                         input logic [31:0] rs1, input logic [4:0] zimm, input bit rs1z, input bit rdz,
                         input logic [31:0] old, input bit ill_rd, input bit ill_wr,
                         input bit rnd, input int hold, input int abort_at);
    logic [31:0] operand;
    bit nz, wen, ro, valid_now, done, finished, aborted;
    int vcnt;
    operand = imm ? {27'd0, zimm} : rs1;
    nz      = imm ? (zimm != 0) : !rs1z;
    wen     = (op == 2'b01) || nz;
`ifdef CSR_ACU_RO_TRAP_EN
    ro = wen && (addr[11:10] == 2'b11);
`else
    ro = 1'b0;
`endif
    txn_id++;
    m_rd     = (op != 2'b00) && !(op == 2'b01 && rdz);
    m_exc    = (op == 2'b00) || (m_rd && ill_rd) || (wen && ill_wr) || ro;
    m_wr     = !m_exc && wen;
    m_old    = (m_rd && !m_exc) ? old : 32'd0;
    m_new    = (op == 2'b01) ? operand : (op == 2'b10) ? (old | operand) : (old & ~operand);
    m_rsp_at = (op == 2'b00) ? 1 : (m_wr ? 3 : 2);
    m_addr   = addr;
    csr_val  = old;
    csr_illegal_rd_i = ill_rd;
    csr_illegal_wr_i = ill_wr;
    req_i = 1'b1; op_i = op; imm_i = imm; addr_i = addr; rs1_data_i = rs1;
    zimm_i = zimm; rs1_zero_i = rs1z; rd_zero_i = rdz;
    forever begin
      clk_en_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk_i);
      if (clk_en_i) break;
      #1;
    end
    #1;
    m_busy = 1; m_age = 1; vcnt = 0; finished = 0; aborted = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (abort_at != 0 && m_age == abort_at) begin
        reset_i = 1'b1;
        m_busy  = 0;
        #1;
        check("wr_low_on_reset", csr_wr_o, 1'b0);
        check("ready_on_reset", req_ready_o, 1'b1);
        @(negedge clk_i);
        #1 reset_i = 1'b0;
        aborted = 1;
        break;
      end
      req_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      op_i = 2'($urandom); imm_i = 1'($urandom); addr_i = 12'($urandom);
      rs1_data_i = $urandom; zimm_i = 5'($urandom);
      rs1_zero_i = 1'($urandom); rd_zero_i = 1'($urandom);
      clk_en_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      valid_now = (m_age >= m_rsp_at);
      rsp_ready_i = rnd ? 1'($urandom_range(0, 1)) : (valid_now && vcnt >= hold);
      @(posedge clk_i);
      done = clk_en_i && rsp_ready_i && valid_now;
      if (valid_now) vcnt++;
      #1;
      if (done) begin m_busy = 0; finished = 1; break; end
      if (clk_en_i) m_age++;
    end
    if (!finished && !aborted) begin
      n_checks++; n_fail++;
      $display("FAIL txn_timeout: txn %0d never completed, expected completion", txn_id);
      m_busy = 0;
    end
    req_i = 1'b0; rsp_ready_i = 1'b0; clk_en_i = 1'b1;
  endtask

  task automatic rand_txn();
    logic [1:0] op; logic [11:0] addr; logic [31:0] rs1; logic [4:0] zimm; bit rs1z;
    op   = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
    addr = 12'($urandom);
    if ($urandom_range(0, 3) == 0) addr[11:10] = 2'b11;
    rs1z = ($urandom_range(0, 3) == 0);
    rs1  = rs1z ? 32'd0 : $urandom;
    zimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    run_txn(op, 1'($urandom), addr, rs1, zimm, rs1z, ($urandom_range(0, 3) == 0), $urandom,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'b1, 0, 0);
  endtask

  initial begin
    int b_wr, b_val, b_rd;
    reset_i = 1'b1; clk_en_i = 1'b1; req_i = 1'b0; op_i = '0; imm_i = 1'b0; addr_i = '0;
    rs1_data_i = '0; zimm_i = '0; rs1_zero_i = 1'b0; rd_zero_i = 1'b0; rsp_ready_i = 1'b0;
    csr_illegal_rd_i = 1'b0; csr_illegal_wr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_req_ready", req_ready_o, 1'b1);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_rsp_exc", rsp_exc_o, 1'b0);
    check("rst_csr_rd", csr_rd_o, 1'b0);
    check("rst_csr_wr", csr_wr_o, 1'b0);
    check("rst_rsp_data", rsp_data_o, 32'd0);
    check("rst_rd_addr", csr_rd_addr_o, 12'd0);
    check("rst_wr_addr", csr_wr_addr_o, 12'd0);
    check("rst_wr_data", csr_wr_data_o, 32'd0);
    @(posedge clk_i); #1 reset_i = 1'b0; chk_en = 1;
    @(posedge clk_i); #1;

    // RW 0x340: read at N+1, write at N+2, response at N+3
    b_wr = obs_wr_cnt;
    run_txn(2'b01, 0, 12'h340, 32'hDEADBEEF, 0, 0, 0, 32'h12345678, 0, 0, 0, 0, 0);
    check("rw_rd_age", obs_rd_age, 1);
    check("rw_wr_age", obs_wr_age, 2);
    check("rw_wr_data", obs_wr_data, 32'hDEADBEEF);
    check("rw_wr_cnt", obs_wr_cnt - b_wr, 1);
    check("rw_rsp_age", obs_rsp_age, 3);
    check("rw_rsp_data", obs_rsp_data, 32'h12345678);

    b_wr = obs_wr_cnt;
    run_txn(2'b10, 0, 12'h300, 32'h000000F0, 0, 0, 0, 32'h0000000F, 0, 0, 0, 0, 0);
    check("rs_wr_data", obs_wr_data, 32'h000000FF);
    check("rs_wr_cnt", obs_wr_cnt - b_wr, 1);

    b_wr = obs_wr_cnt;
    run_txn(2'b11, 1, 12'h305, 32'hFFFFFFFF, 0, 0, 0, 32'h0000A5A5, 0, 0, 0, 0, 0);
    check("rc_zimm0_wr_cnt", obs_wr_cnt - b_wr, 0);
    check("rc_zimm0_rsp_data", obs_rsp_data, 32'h0000A5A5);
    check("rc_zimm0_rsp_age", obs_rsp_age, 2);

    b_wr = obs_wr_cnt;
    run_txn(2'b10, 0, 12'h7C0, 32'h00000001, 0, 0, 0, 32'h55555555, 1, 0, 0, 0, 0);
    check("ill_rd_exc", obs_rsp_exc, 1'b1);
    check("ill_rd_rsp_data", obs_rsp_data, 32'd0);
    check("ill_rd_wr_cnt", obs_wr_cnt - b_wr, 0);

    // response held for 3 cycles with req_i high throughout
    b_wr = obs_wr_cnt; b_val = obs_val_cnt; b_rd = obs_rd_cnt;
    run_txn(2'b01, 0, 12'h341, 32'h0BADF00D, 0, 0, 0, 32'hCAFEF00D, 0, 0, 0, 3, 0);
    check("hold_val_cycles", obs_val_cnt - b_val, 4);
    check("hold_rd_cnt", obs_rd_cnt - b_rd, 1);
    check("hold_wr_cnt", obs_wr_cnt - b_wr, 1);
    check("hold_rsp_data", obs_rsp_data, 32'hCAFEF00D);

    // reset while in WRITE: nothing completes
    b_wr = obs_wr_cnt; b_val = obs_val_cnt;
    run_txn(2'b01, 0, 12'h342, 32'h11112222, 0, 0, 0, 32'h33334444, 0, 0, 0, 0, 2);
    repeat (4) @(posedge clk_i);
    #1;
    check("abort_wr_cnt", obs_wr_cnt - b_wr, 0);
    check("abort_val_cnt", obs_val_cnt - b_val, 0);

    b_wr = obs_wr_cnt;
    run_txn(2'b01, 0, 12'hC00, 32'h00000077, 0, 0, 0, 32'h00000001, 0, 0, 0, 0, 0);
`ifdef CSR_ACU_RO_TRAP_EN
    check("ro_exc", obs_rsp_exc, 1'b1);
    check("ro_wr_cnt", obs_wr_cnt - b_wr, 0);
`else
    check("ro_exc", obs_rsp_exc, 1'b0);
    check("ro_wr_cnt", obs_wr_cnt - b_wr, 1);
`endif

    run_txn(2'b00, 0, 12'h100, 32'h1, 0, 0, 0, 32'h9, 0, 0, 0, 0, 0);
    check("rsv_exc", obs_rsp_exc, 1'b1);
    check("rsv_rsp_age", obs_rsp_age, 1);

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        clk_en_i = 1'($urandom); req_i = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk_i);
        #1;
      end
      rand_txn();
    end

    @(posedge clk_i); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 SHALL have parameter C_XLEN, default 32, the CSR and GPR data width.
REQ-002 SHALL have ports in this order: clk_i  in  1  clock, rising edge; reset_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port clk_en_i  in  1  pipeline clock enable; all state advances only when high.
REQ-004 SHALL have request ports: req_i in 1 valid; req_ready_o out 1 accept; op_i in 2 (01 RW, 10 RS, 11 RC, 00 reserved); imm_i in 1 use zimm_i; addr_i in 12; rs1_data_i in C_XLEN; zimm_i in 5; rs1_zero_i in 1 rs1 field is x0; rd_zero_i in 1 rd is x0.
REQ-005 SHALL have response ports: rsp_valid_o out 1; rsp_ready_i in 1; rsp_data_o out C_XLEN old CSR value; rsp_exc_o out 1 illegal-instruction flag.
REQ-006 SHALL have CSR-file ports: csr_rd_o out 1; csr_rd_addr_o out 12; csr_rd_data_i in C_XLEN; csr_wr_o out 1; csr_wr_addr_o out 12; csr_wr_data_o out C_XLEN; csr_illegal_rd_i in 1; csr_illegal_wr_i in 1.

Function
REQ-007 SHALL implement FSM IDLE, READ, WRITE, RESP; req_ready_o high only in IDLE.
REQ-008 IDLE: on req_i & clk_en_i, SHALL latch op, addr, operand (imm_i ? zero-extended zimm_i : rs1_data_i) and suppress flags; op 00 -> RESP with exception; else -> READ.
REQ-009 Operand zero test for RS/RC SHALL use rs1_zero_i when imm_i=0 and zimm_i==0 when imm_i=1.
REQ-010 READ: csr_rd_o = clk_en_i & ~(op==RW & rd_zero); SHALL sample csr_rd_data_i, csr_illegal_rd_i (only when reading), csr_illegal_wr_i (only when writing) in the same cycle; CSR file read is combinational.
REQ-011 Write enable: RW always; RS/RC only if operand nonzero.
REQ-012 New value: RW operand; RS old | operand; RC old & ~operand; full C_XLEN width, no carries.
REQ-013 READ -> RESP if exception or write disabled, else -> WRITE.
REQ-014 WRITE: csr_wr_o = clk_en_i for exactly one enabled cycle, addr/data stable, then -> RESP.
REQ-015 RESP: rsp_valid_o high; rsp_data_o = sampled old value (0 if read suppressed or exception); hold stable until rsp_ready_i & clk_en_i, then -> IDLE.
REQ-016 Latency with no stall: accept cycle N, csr_rd_o N+1, csr_wr_o N+2, rsp_valid_o N+3 (N+2 when write skipped).
REQ-017 csr_rd_o, csr_wr_o SHALL never assert in the same cycle, nor outside READ/WRITE; an exception SHALL never produce csr_wr_o.
REQ-018 req_i while not IDLE SHALL be ignored.

Reset
REQ-019 reset_i SHALL immediately force IDLE; req_ready_o=1, rsp_valid_o=0, rsp_exc_o=0, csr_rd_o=0, csr_wr_o=0, all data/address outputs 0.
REQ-020 Reset mid-operation SHALL abort the access with no write issued and no response.

Configuration
REQ-021 Macro CSR_ACU_RO_TRAP_EN defined: writes to addr[11:10]==2'b11 SHALL raise exception locally, regardless of csr_illegal_wr_i.
REQ-022 Undefined: read-only space SHALL be enforced only via csr_illegal_wr_i.

Structure
REQ-023 Package csr_acu_pkg SHALL hold op encodings, FSM state type, read-only address field constant.
REQ-024 Sub-module csr_acu_alu (combinational RW/RS/RC new-value computation) SHALL be instantiated once.

Verification
REQ-025 RW addr 0x340, rs1=0xDEADBEEF, CSR=0x12345678 -> csr_rd_o N+1, csr_wr_o N+2 data 0xDEADBEEF, rsp_data_o 0x12345678 at N+3.
REQ-026 RS rs1=0x000000F0, old 0x0000000F -> write 0x000000FF; RC imm zimm=0 -> no csr_wr_o, rsp_data_o old, rsp at N+2.
REQ-027 csr_illegal_rd_i=1 on RS -> rsp_exc_o=1, rsp_data_o=0, no csr_wr_o.
REQ-028 rsp_ready_i low 3 cycles, req_i held high -> rsp_valid_o/rsp_data_o stable, req_ready_o low, no new access.
REQ-029 reset_i pulsed in WRITE -> csr_wr_o low same cycle, IDLE, rsp_valid_o never asserts.
REQ-030 RW addr 0xC00, csr_illegal_wr_i=0 -> with CSR_ACU_RO_TRAP_EN rsp_exc_o=1, no write; without, write issued.
